// File: rtl/bpu_update_sched_if.sv
// Bundle between the commit/decode producers and the pcgen update scheduler.
// Handshake: a transfer happens on the edge where valid and ready are both high. A producer
// holds valid and payload stable until then. Ready depends only on registered state.
interface bpu_update_sched_if;
  logic        upd_valid_i;
  logic        upd_ready_o;
  logic [1:0]  upd_kind_i;
  logic [29:0] upd_vpc_i;
  logic [29:0] upd_target_i;
  logic [1:0]  upd_cntr_i;
  logic        upd_tkn_i;
  logic [1:0]  upd_btype_i;
  logic        upd_way_i;

  logic        corr_valid_i;
  logic [29:0] corr_pc_i;
  logic        corr_ready_o;

  logic [29:0] c1_btb_vpc_o;
  logic [29:0] c1_btb_target_o;
  logic [1:0]  c1_cntr_pred_o;
  logic        c1_bnch_tkn_o;
  logic [1:0]  c1_bnch_type_o;
  logic        c1_btb_way_o;
  logic        c1_btb_mod_o;
  logic        c1_btb_bm_o;
  logic        c1_call_affirm_o;
  logic        c1_ret_affirm_o;
  logic        btb_correct_o;
  logic [29:0] btb_correct_pc_o;

  modport slave (
    input  upd_valid_i, upd_kind_i, upd_vpc_i, upd_target_i, upd_cntr_i, upd_tkn_i,
           upd_btype_i, upd_way_i, corr_valid_i, corr_pc_i,
    output upd_ready_o, corr_ready_o, c1_btb_vpc_o, c1_btb_target_o, c1_cntr_pred_o,
           c1_bnch_tkn_o, c1_bnch_type_o, c1_btb_way_o, c1_btb_mod_o, c1_btb_bm_o,
           c1_call_affirm_o, c1_ret_affirm_o, btb_correct_o, btb_correct_pc_o
  );

  modport master (
    output upd_valid_i, upd_kind_i, upd_vpc_i, upd_target_i, upd_cntr_i, upd_tkn_i,
           upd_btype_i, upd_way_i, corr_valid_i, corr_pc_i,
    input  upd_ready_o, corr_ready_o, c1_btb_vpc_o, c1_btb_target_o, c1_cntr_pred_o,
           c1_bnch_tkn_o, c1_bnch_type_o, c1_btb_way_o, c1_btb_mod_o, c1_btb_bm_o,
           c1_call_affirm_o, c1_ret_affirm_o, btb_correct_o, btb_correct_pc_o
  );
endinterface

// File: rtl/bpu_update_sched.sv
// Serialises commit-side predictor updates (FIFO) and decode-side BTB invalidations (1-entry slot)
// into at most one registered pcgen update per cycle.
module bpu_update_sched #(
  parameter int QDEPTH = 4
) (
  input  logic              core_clock_i,
  input  logic              core_reset_ni,
  input  logic              core_flush_i,
  bpu_update_sched_if.slave upd_bus,
  output logic              dbg_state_o
);
  localparam int          AW   = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam logic [AW:0] FULL = (AW+1)'(QDEPTH);

  localparam logic [1:0] K_BM   = 2'b00;
  localparam logic [1:0] K_MOD  = 2'b01;
  localparam logic [1:0] K_CALL = 2'b10;
  localparam logic [1:0] K_RET  = 2'b11;

  typedef enum logic {ST_RUN = 1'b0, ST_SETTLE = 1'b1} state_e;

  typedef struct packed {
    logic [29:0] vpc;
    logic [29:0] target;
    logic [1:0]  cntr;
    logic        tkn;
    logic [1:0]  btype;
    logic        way;
  } pay_t;

  typedef struct packed {
    logic [1:0] kind;
    pay_t       pay;
  } entry_t;

  state_e        state_q, state_d;
  entry_t        mem_q [QDEPTH];
  entry_t        head, in_entry;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          slot_v_q, slot_v_d;
  logic [29:0]   slot_pc_q, slot_pc_d;
  logic          last_s_q, last_s_d;
  logic          q_ready, s_ready, push, pop;
  logic          h_pend, h_mod, s_pend, grant_h, grant_s;
  logic          mod_q, bm_q, call_q, ret_q, corr_q;
  pay_t          pay_q;
  logic [29:0]   corr_pc_q;

  assign in_entry = '{kind: upd_bus.upd_kind_i,
                      pay: '{vpc: upd_bus.upd_vpc_i, target: upd_bus.upd_target_i,
                             cntr: upd_bus.upd_cntr_i, tkn: upd_bus.upd_tkn_i,
                             btype: upd_bus.upd_btype_i, way: upd_bus.upd_way_i}};

  assign q_ready = (cnt_q != FULL);
  assign s_ready = ~slot_v_q;
  assign push    = upd_bus.upd_valid_i & q_ready;
  assign head    = mem_q[rd_ptr_q];
  assign h_pend  = (cnt_q != '0);
  assign h_mod   = (head.kind == K_MOD);
  // A flush kills the slot this very cycle, so it must not compete for the grant.
  assign s_pend  = slot_v_q & ~core_flush_i;
  assign pop     = grant_h;
  assign cnt_d   = cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

  always_comb begin
    state_d = state_q;
    grant_h = 1'b0;
    grant_s = 1'b0;
    case (state_q)
      ST_RUN: begin
        // last_s_q set means the slot won the previous grant, so the queue goes next.
        grant_h = h_pend & (h_mod | ~s_pend | last_s_q);
        grant_s = s_pend & ~grant_h;
        if (grant_h && h_mod) state_d = ST_SETTLE;
      end
      ST_SETTLE: state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
  end

  always_comb begin
    slot_v_d  = slot_v_q;
    slot_pc_d = slot_pc_q;
    last_s_d  = last_s_q;
    if (grant_s)      last_s_d = 1'b1;
    else if (grant_h) last_s_d = 1'b0;
    // Anything in or arriving at the slot during SETTLE was fetched on the wrong path.
    if (core_flush_i || state_q == ST_SETTLE || grant_s) begin
      slot_v_d = 1'b0;
    end else if (upd_bus.corr_valid_i && s_ready) begin
      slot_v_d  = 1'b1;
      slot_pc_d = upd_bus.corr_pc_i;
    end
  end

  always_ff @(posedge core_clock_i) begin
    if (push) mem_q[wr_ptr_q] <= in_entry;
  end

  always_ff @(posedge core_clock_i or negedge core_reset_ni) begin
    if (!core_reset_ni) begin
      state_q   <= ST_RUN;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      slot_v_q  <= 1'b0;
      slot_pc_q <= '0;
      last_s_q  <= 1'b0;
      mod_q     <= 1'b0;
      bm_q      <= 1'b0;
      call_q    <= 1'b0;
      ret_q     <= 1'b0;
      corr_q    <= 1'b0;
      pay_q     <= '0;
      corr_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      slot_v_q  <= slot_v_d;
      slot_pc_q <= slot_pc_d;
      last_s_q  <= last_s_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      mod_q  <= grant_h & (head.kind == K_MOD);
      bm_q   <= grant_h & (head.kind == K_BM);
      call_q <= grant_h & (head.kind == K_CALL);
      ret_q  <= grant_h & (head.kind == K_RET);
      corr_q <= grant_s;
      if (grant_h) pay_q     <= head.pay;
      if (grant_s) corr_pc_q <= slot_pc_q;
    end
  end

  assign upd_bus.upd_ready_o      = q_ready;
  assign upd_bus.corr_ready_o     = s_ready;
  assign upd_bus.c1_btb_vpc_o     = pay_q.vpc;
  assign upd_bus.c1_btb_target_o  = pay_q.target;
  assign upd_bus.c1_cntr_pred_o   = pay_q.cntr;
  assign upd_bus.c1_bnch_tkn_o    = pay_q.tkn;
  assign upd_bus.c1_bnch_type_o   = pay_q.btype;
  assign upd_bus.c1_btb_way_o     = pay_q.way;
  assign upd_bus.c1_btb_mod_o     = mod_q;
  assign upd_bus.c1_btb_bm_o      = bm_q;
  assign upd_bus.c1_call_affirm_o = call_q;
  assign upd_bus.c1_ret_affirm_o  = ret_q;
  assign upd_bus.btb_correct_o    = corr_q;
  assign upd_bus.btb_correct_pc_o = corr_pc_q;
  assign dbg_state_o              = state_q;
endmodule
